// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU datapath blocks around the StMM matrix unit.
package npu_pkg;

  // Drain FSM: waiting for a result row, or streaming a captured row out.
  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

  // Number of output beats needed to carry a p-element vector, beat_bytes elements per beat.
  function automatic int beats(input int p, input int beat_bytes);
    return p / beat_bytes;
  endfunction

endpackage

// File: rtl/stmm_y_beat_sel.sv
// Snapshot store for one StMM result row, with the ReLU clamp applied as the row is captured.
// The beat index comes from a register in the parent, so the output beat changes only
// when that index register advances.
module stmm_y_beat_sel
  import npu_pkg::*;
#(
  parameter int P          = 704,
  parameter int Q          = 8,
  parameter int BEAT_BYTES = 16,
  parameter int KW         = 6
) (
  input  logic                  clk,
  input  logic                  capture,
  input  logic                  relu_en,
  input  logic [Q*P-1:0]        y_in,
  input  logic [KW-1:0]         beat_idx,
  output logic [Q*BEAT_BYTES-1:0] beat_data
);

  localparam int BEATS  = beats(P, BEAT_BYTES);
  localparam int BEAT_W = Q * BEAT_BYTES;

  logic [Q*P-1:0]                clamped;
  logic [BEATS-1:0][BEAT_W-1:0]  snap;

  // Optional ReLU: any element whose sign bit is set becomes zero, others pass untouched.
  always_comb begin
    clamped = y_in;
    for (int i = 0; i < P; i++) begin
      if (relu_en && y_in[Q*i+Q-1]) begin
        clamped[Q*i +: Q] = '0;
      end
    end
  end

  // Row snapshot; contents are only meaningful after a capture, so no reset is needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      snap <= clamped;
    end
  end

  assign beat_data = snap[beat_idx];

endmodule

// File: rtl/stmm_y_drain.sv
// Drains one StMM result row into the activation buffer as addressed valid/ready beats.
// The row is snapshotted on the rising edge of y_valid so the StMM can start its next row
// while this one streams out.
module stmm_y_drain
  import npu_pkg::*;
#(
  parameter int P          = 704,
  parameter int Q          = 8,
  parameter int BEAT_BYTES = 16,
  parameter int ADDR_W     = 16
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic [Q*P-1:0]          y_in,
  input  logic                    y_valid,
  input  logic                    relu_en,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    clr,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [Q*BEAT_BYTES-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int BEATS = beats(P, BEAT_BYTES);
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);

  if (P % BEAT_BYTES != 0) begin : g_bad_geometry
    $error("stmm_y_drain: P must be a multiple of BEAT_BYTES");
  end

  drain_state_t                state, state_nxt;
  logic [KW-1:0]               k;
  logic [ADDR_W-1:0]           base_q;
  logic                        y_valid_d;
  logic                        done_q;
  logic                        overrun_q;
  logic                        rise;
  logic                        hs;
  logic                        last_hs;
  logic                        capture;
  logic [Q*BEAT_BYTES-1:0]     beat_data;

  // A new row is taken only from IDLE, or on the very cycle the previous row finishes,
  // so a mid-drain rise never disturbs the snapshot being streamed.
  assign rise    = y_valid & ~y_valid_d;
  assign hs      = (state == STREAM) & m_ready;
  assign last_hs = hs & (k == LAST_K);
  assign capture = rise & ((state == IDLE) | last_hs);

  stmm_y_beat_sel #(
    .P          (P),
    .Q          (Q),
    .BEAT_BYTES (BEAT_BYTES),
    .KW         (KW)
  ) u_beat_sel (
    .clk       (clk),
    .capture   (capture),
    .relu_en   (relu_en),
    .y_in      (y_in),
    .beat_idx  (k),
    .beat_data (beat_data)
  );

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: start on capture, fall back to IDLE after the last beat unless a new row chains in.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = STREAM;
      STREAM:  if (last_hs && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter, base address capture and y_valid edge history.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      k         <= '0;
      base_q    <= '0;
      y_valid_d <= 1'b0;
    end else begin
      y_valid_d <= y_valid;
      if (capture) begin
        k      <= '0;
        base_q <= base_addr;
      end else if (last_hs) begin
        k <= '0;
      end else if (hs) begin
        k <= k + KW'(1);
      end
    end
  end

  // Completion pulse and sticky overrun; a new overrun wins over a simultaneous clear.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= last_hs;
      if (rise && (state == STREAM) && !last_hs) overrun_q <= 1'b1;
      else if (clr)                              overrun_q <= 1'b0;
    end
  end

  assign busy    = (state == STREAM);
  assign m_valid = busy;
  assign m_addr  = busy ? base_q + ADDR_W'(k) : '0;
  assign m_data  = busy ? beat_data : '0;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
